// File: rtl/mem_pkg.sv
// Shared constants and types for the data-memory interface.
// Optional feature macro used elsewhere: WBUF_COALESCE_EN.
package mem_pkg;

  localparam int DATA_W         = 16;
  localparam int ADDR_W         = 12;
  localparam int WBUF_DEPTH_DEF = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wbuf_entry_t;

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

endpackage

// File: rtl/data_mem_if_if.sv
// Core-side request/response bus of the data-memory interface.
// master = core, slave = memory interface.
interface dmem_bus_if;
  import mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we,
    output req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we,
    input  req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/data_mem_if_wbuf.sv
// Posted-write FIFO with newest-match lookup.
// WBUF_COALESCE_EN adds an in-place data overwrite path.
module wbuf_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  wbuf_entry_t       push_data_i,
  input  logic              pop_i,
  output wbuf_entry_t       head_o,
  output logic              full_o,
  output logic              empty_o,
  input  logic [ADDR_W-1:0] look_addr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] hit_data_o
`ifdef WBUF_COALESCE_EN
  ,
  input  logic              coal_i,
  input  logic [DATA_W-1:0] coal_data_i,
  output logic              hit_head_o
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] idx;
  logic [PW:0]   cnt_q, cnt_d;
  wbuf_entry_t   buf_q [DEPTH];
`ifdef WBUF_COALESCE_EN
  logic [PW-1:0] hit_idx;
`endif

  assign head_o  = buf_q[head_q];
  assign full_o  = cnt_q == (PW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;

  // walk oldest to newest so the last match wins
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    idx        = '0;
`ifdef WBUF_COALESCE_EN
    hit_idx    = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((PW+1)'(i) < cnt_q &&
          buf_q[idx].addr == look_addr_i) begin
        hit_o      = 1'b1;
        hit_data_o = buf_q[idx].data;
`ifdef WBUF_COALESCE_EN
        hit_idx    = idx;
`endif
      end
    end
  end

`ifdef WBUF_COALESCE_EN
  assign hit_head_o = hit_o && hit_idx == head_q;
`endif

  always_comb begin
    head_d = head_q + PW'(pop_i);
    tail_d = tail_q + PW'(push_i);
    cnt_d  = cnt_q + (PW+1)'(push_i)
                   - (PW+1)'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) buf_q[tail_q] <= push_data_i;
`ifdef WBUF_COALESCE_EN
    if (coal_i) buf_q[hit_idx].data <= coal_data_i;
`endif
  end

endmodule

// File: rtl/data_mem_if.sv
// Data-memory front end: posted write buffer, RAW forwarding, flush FSM.
// Build with WBUF_COALESCE_EN to merge stores into matching entries.
module data_mem_if
  import mem_pkg::*;
#(
  parameter int WBUF_DEPTH = WBUF_DEPTH_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  dmem_bus_if.slave bus,
  input  logic      flush_req,
  output logic      flush_done,
  output logic      busy
);

  logic full, empty, hit, ready, can_take;
  logic hs, ld_go, st_go, pop, push, coal;
  logic [DATA_W-1:0] hit_data;
  wbuf_entry_t head;
  logic [0:0] state_q, state_d;
  logic en_q, armed_q, armed_d, done_q, done_d;
  logic ld_q, hit_q, rspv_q;
  logic [DATA_W-1:0] hdata_q, rd_q, rdata_q;
  logic [DATA_W-1:0] ram_q [2**ADDR_W];
`ifdef WBUF_COALESCE_EN
  logic hit_head;
`endif

  wbuf_fifo #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_data_i({bus.req_addr, bus.req_wdata}),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty),
    .look_addr_i(bus.req_addr),
    .hit_o      (hit),
    .hit_data_o (hit_data)
`ifdef WBUF_COALESCE_EN
    ,
    .coal_i     (coal),
    .coal_data_i(bus.req_wdata),
    .hit_head_o (hit_head)
`endif
  );

  always_comb begin
    can_take = !full;
`ifdef WBUF_COALESCE_EN
    can_take = !full || (bus.req_we && hit);
`endif
    ready = en_q && state_q == RUN && can_take;
  end

  assign hs    = bus.req_valid && ready;
  assign ld_go = hs && !bus.req_we;
  assign st_go = hs && bus.req_we;
  // loads own the RAM port; reset discards instead of draining
  assign pop   = rst_n && !empty && !ld_go;

`ifdef WBUF_COALESCE_EN
  // never merge into the head while it is leaving
  assign coal = st_go && hit && !(pop && hit_head);
`else
  assign coal = 1'b0;
`endif
  assign push = st_go && !coal;

  always_comb begin
    state_d = state_q;
    armed_d = armed_q | ~flush_req;
    done_d  = 1'b0;
    unique case (1'b1)
      state_q == RUN: begin
        if (flush_req && armed_q && !hs) begin
          state_d = FLUSH;
          armed_d = 1'b0;
        end
      end
      state_q == FLUSH: begin
        if (empty) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      en_q    <= 1'b0;
      armed_q <= 1'b1;
      done_q  <= 1'b0;
      ld_q    <= 1'b0;
      hit_q   <= 1'b0;
      hdata_q <= '0;
      rspv_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= 1'b1;
      armed_q <= armed_d;
      done_q  <= done_d;
      ld_q    <= ld_go;
      if (ld_go) begin
        hit_q   <= hit;
        hdata_q <= hit_data;
      end
      rspv_q <= ld_q;
      if (ld_q) rdata_q <= hit_q ? hdata_q : rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (pop)   ram_q[head.addr] <= head.data;
    if (ld_go) rd_q <= ram_q[bus.req_addr];
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rspv_q;
  assign bus.rsp_rdata = rdata_q;
  assign flush_done    = done_q;
  assign busy          = !empty || state_q == FLUSH;

endmodule

// File: tb/tb_data_mem_if.sv
// Random + directed bench for data_mem_if against a queue/array model.
// Honours WBUF_COALESCE_EN in the model when defined.
module tb_data_mem_if;

  localparam int DEPTH = 4;
  localparam int NA    = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_req = 1'b0;
  logic flush_done, busy;

  dmem_bus_if bus();

  data_mem_if #(.WBUF_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .flush_req (flush_req),
    .flush_done(flush_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] a;
    logic [15:0] d;
  } wr_t;
  typedef struct {
    logic [15:0] d;
    int          e;
  } rd_t;

  wr_t wq[$];
  rd_t rq[$];
  logic [15:0] ram_m [NA];
  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  int since_rst = 0;
  bit in_fl = 1'b0;
  logic rdy_s, done_s, busy_s;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  // what software should see: newest buffered value, else RAM
  function automatic logic [15:0] view(
      input logic [11:0] a);
    logic [15:0] v;
    v = ram_m[a[5:0]];
    foreach (wq[i]) if (wq[i].a == a) v = wq[i].d;
    return v;
  endfunction

  task automatic step(input logic v, input logic we,
                      input logic [11:0] a,
                      input logic [15:0] d);
    bit hs, ld, st, pop, mhit, exp_now;
    int ci;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    #1;
    rdy_s = bus.req_ready;
    mhit = 1'b0;
`ifdef WBUF_COALESCE_EN
    foreach (wq[i]) if (we && wq[i].a == a) mhit = 1'b1;
`endif
    if (rst_n && !in_fl && since_rst > 0)
      chk("req_ready", rdy_s,
          wq.size() < DEPTH || mhit);
    hs = v && rdy_s;
    ld = hs && !we;
    st = hs && we;
    @(posedge clk);
    edge_n++;
    if (!rst_n) begin
      wq.delete();
      rq.delete();
      since_rst = 0;
    end else begin
      since_rst++;
      if (ld) rq.push_back('{view(a), edge_n});
      pop = wq.size() > 0 && !ld;
      ci = -1;
`ifdef WBUF_COALESCE_EN
      if (st)
        foreach (wq[i]) if (wq[i].a == a) ci = i;
      if (pop && ci == 0) ci = -1;
`endif
      if (ci >= 0) wq[ci].d = d;
      if (pop) begin
        ram_m[wq[0].a[5:0]] = wq[0].d;
        void'(wq.pop_front());
      end
      if (st && ci < 0) wq.push_back('{a, d});
    end
    #1;
    done_s = flush_done;
    busy_s = busy;
    // accepted at edge e, core captures it at edge e+2
    exp_now = rq.size() > 0 &&
              edge_n + 1 == rq[0].e + 2;
    chk("rsp_valid", bus.rsp_valid, exp_now);
    if (exp_now) begin
      chk("rsp_rdata", bus.rsp_rdata, rq[0].d);
      void'(rq.pop_front());
    end
    if (!in_fl) begin
      chk("flush_idle", done_s, 0);
      if (rst_n)
        chk("busy", busy_s, wq.size() != 0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 12'h0, 16'h0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      step(0, 0, 12'h0, 16'h0);
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_rspv", bus.rsp_valid, 0);
      chk("rst_rdata", bus.rsp_rdata, 0);
      chk("rst_done", flush_done, 0);
      chk("rst_busy", busy, 0);
    end
    rst_n = 1'b1;
  endtask

  task automatic do_flush();
    int c, want;
    bit seen;
    in_fl = 1'b1;
    flush_req = 1'b1;
    c = wq.size();
    step(0, 0, 12'h0, 16'h0);
    // one drain per cycle, pulse one cycle after empty
    want = edge_n + (c > 0 ? c : 1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(0, 0, 12'h0, 16'h0);
      chk("flush_rdy", rdy_s, 0);
      if (done_s) begin
        seen = 1'b1;
        chk("flush_edge", edge_n, want);
        chk("flush_busy", busy_s, 0);
      end
    end
    if (!seen) chk("flush_timeout", 0, 1);
    repeat (3) begin
      step(0, 0, 12'h0, 16'h0);
      chk("flush_rearm", done_s, 0);
    end
    flush_req = 1'b0;
    in_fl = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  initial begin
    logic [11:0] ra;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    do_reset(3);
    idle(2);

    for (int i = 0; i < NA; i++)
      step(1, 1, 12'(i), 16'($urandom));
    do_flush();

    step(1, 1, 12'h010, 16'hBEEF);
    step(1, 0, 12'h010, 16'h0);
    idle(3);

    for (int i = 1; i <= 4; i++)
      step(1, 1, 12'(i), 16'(16'hA000 + i));
    idle(2);
    for (int i = 1; i <= 4; i++)
      step(1, 0, 12'(i), 16'h0);
    idle(3);

    step(1, 1, 12'h030, 16'h1234);
    do_flush();
    for (int i = 1; i <= 3; i++)
      step(1, 1, 12'(12'h030 + i), 16'(16'hC000 + i));
    repeat (5) step(1, 0, 12'h030, 16'h0);
    idle(4);

    for (int i = 0; i < 3; i++)
      step(1, 1, 12'(12'h008 + i), 16'(16'hD000 + i));
    do_flush();
    for (int i = 0; i < 3; i++)
      step(1, 0, 12'(12'h008 + i), 16'h0);
    idle(3);

    step(1, 1, 12'h020, 16'h1111);
    step(1, 1, 12'h020, 16'h2222);
    do_reset(1);
    idle(1);
    step(1, 0, 12'h020, 16'h0);
    idle(3);

    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 75) do_flush();
      else if (n == 300) do_reset(1);
      else begin
        ra = ($urandom % 2) ? 12'($urandom % 4)
                            : 12'($urandom % NA);
        step($urandom % 4 != 0, 1'($urandom % 2),
             ra, 16'($urandom));
      end
    end
    idle(4);
    chk("rsp_drained", rq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
